// File: rtl/i2c_mem_sequencer.sv
// I2C master sequencer for single-byte memory writes and random reads over an
// open-drain SCL/SDA pair; one command in flight, single-cycle response strobe.
module i2c_mem_sequencer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, SEND_BYTE, GET_ACK, RSTART, READ_BYTE, SEND_NACK, STOP, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    step_q, step_d;
  logic          rw_q, rw_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0]    tx_q, tx_d, rx_q, rx_d;
  logic          nack_q, nack_d;
  logic          scl_q, scl_d, oe_q, oe_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_nack_q, rsp_nack_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic          busy_q, busy_d, ready_q, ready_d;
  logic          sample, sym_end, scl_mid;

  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_nack  = rsp_nack_q;
  assign busy      = busy_q;
  assign scl       = scl_q;
  assign sda_oe    = oe_q;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    qtr_d       = qtr_q;
    bit_d       = bit_q;
    step_d      = step_q;
    rw_d        = rw_q;
    dev_d       = dev_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    nack_d      = nack_q;
    rsp_nack_d  = rsp_nack_q;
    rsp_rdata_d = rsp_rdata_q;
    sample      = (div_q == DMAX) && (qtr_q == 2'd1);
    sym_end     = (div_q == DMAX) && (qtr_q == 2'd3);

    if (state_q != IDLE && state_q != DONE) begin
      if (div_q == DMAX) begin
        div_d = '0;
        qtr_d = qtr_q + 2'd1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: if (cmd_valid && ready_q) begin
        state_d = START;
        rw_d    = cmd_rw;
        dev_d   = cmd_dev;
        addr_d  = cmd_addr;
        wdata_d = cmd_wdata;
        tx_d    = {cmd_dev, 1'b0};
        step_d  = 2'd0;
        nack_d  = 1'b0;
        bit_d   = '0;
        div_d   = '0;
        qtr_d   = '0;
      end
      START: if (sym_end) state_d = SEND_BYTE;
      SEND_BYTE: if (sym_end) begin
        tx_d  = {tx_q[6:0], 1'b0};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = GET_ACK;
      end
      GET_ACK: begin
        if (sample) nack_d = sda_in;
        // step_q tracks which byte was just acknowledged: dev-w, mem addr, data/dev-r
        if (sym_end) begin
          if (nack_q) begin
            state_d = STOP;
          end else begin
            unique case (step_q)
              2'd0: begin
                tx_d    = addr_q;
                step_d  = 2'd1;
                state_d = SEND_BYTE;
              end
              2'd1: begin
                if (rw_q) begin
                  state_d = RSTART;
                end else begin
                  tx_d    = wdata_q;
                  step_d  = 2'd2;
                  state_d = SEND_BYTE;
                end
              end
              default: state_d = rw_q ? READ_BYTE : STOP;
            endcase
          end
        end
      end
      RSTART: if (sym_end) begin
        tx_d    = {dev_q, 1'b1};
        step_d  = 2'd2;
        state_d = SEND_BYTE;
      end
      READ_BYTE: begin
        if (sample) rx_d = {rx_q[6:0], sda_in};
        if (sym_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = SEND_NACK;
        end
      end
      SEND_NACK: if (sym_end) state_d = STOP;
      STOP: if (sym_end) begin
        state_d    = DONE;
        rsp_nack_d = nack_q;
        if (nack_q) rsp_rdata_d = '0;
        else if (rw_q) rsp_rdata_d = rx_q;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus levels are derived from the next position so the registered pins line up with it
    scl_mid = (qtr_d == 2'd1) || (qtr_d == 2'd2);
    scl_d   = 1'b1;
    oe_d    = 1'b0;
    unique case (state_d)
      START, RSTART: begin
        scl_d = scl_mid;
        oe_d  = qtr_d[1];
      end
      SEND_BYTE: begin
        scl_d = scl_mid;
        oe_d  = ~tx_d[7];
      end
      GET_ACK, READ_BYTE, SEND_NACK: scl_d = scl_mid;
      STOP: begin
        scl_d = (qtr_d != 2'd0);
        oe_d  = ~qtr_d[1];
      end
      default: ;
    endcase

    rsp_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    ready_d     = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      qtr_q       <= '0;
      bit_q       <= '0;
      step_q      <= '0;
      rw_q        <= 1'b0;
      dev_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      nack_q      <= 1'b0;
      scl_q       <= 1'b1;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_nack_q  <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      step_q      <= step_d;
      rw_q        <= rw_d;
      dev_q       <= dev_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      nack_q      <= nack_d;
      scl_q       <= scl_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_nack_q  <= rsp_nack_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

endmodule

// File: tb/tb_i2c_mem_sequencer.sv
// Bench for i2c_mem_sequencer: behavioural I2C memory slave on the bus, a
// transaction-level reference model feeding a scoreboard, and a response monitor.
module tb_i2c_mem_sequencer;

  localparam int CLK_DIV = 4;
  localparam int BIT_CYC = 4 * CLK_DIV;
  localparam logic [6:0] SLV_DEV = 7'h50;
  localparam int M_IDLE = 0, M_DEV = 1, M_ADDR = 2, M_DATA = 3, M_TX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
  logic [6:0] cmd_dev = '0;
  logic [7:0] cmd_addr = '0, cmd_wdata = '0;
  logic rsp_valid, rsp_nack, busy, scl, sda_oe, sda_in;
  logic [7:0] rsp_rdata;

  i2c_mem_sequencer #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_dev(cmd_dev), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .busy(busy),
    .scl(scl), .sda_oe(sda_oe), .sda_in(sda_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    return (i == 16) ? 8'h5A : 8'(i * 29 + 7);
  endfunction

  // ---------------- behavioural slave ----------------
  logic       slv_pull = 1'b0;
  logic       slv_nack_data = 1'b0;
  logic       slv_inited = 1'b0;
  logic [7:0] slv_mem [256];
  logic [7:0] slv_sh = '0, slv_ptr = '0, slv_tx = '0;
  int         slv_mode = M_IDLE, slv_next = M_IDLE, slv_bits = 0, slv_starts = 0;
  logic       slv_mack = 1'b0;
  logic [7:0] rx_log [$];
  logic       scl_prev = 1'b1, sda_prev = 1'b1, line;

  assign sda_in = ~(sda_oe | slv_pull);

  always @(scl or sda_oe or rst) begin
    line = ~(sda_oe | slv_pull);
    if (rst) begin
      if (!slv_inited) begin
        for (int i = 0; i < 256; i++) slv_mem[i] = init_val(i);
        slv_inited = 1'b1;
      end
      slv_mode = M_IDLE;
      slv_pull = 1'b0;
      slv_bits = 0;
    end else if (scl && scl_prev && sda_prev && !line) begin
      if (slv_mode == M_IDLE) begin
        rx_log.delete();
        slv_starts = 0;
        slv_mack = 1'b0;
      end
      slv_starts++;
      slv_mode = M_DEV;
      slv_bits = 0;
      slv_pull = 1'b0;
    end else if (scl && scl_prev && !sda_prev && line) begin
      slv_mode = M_IDLE;
      slv_pull = 1'b0;
    end else if (scl && !scl_prev) begin
      if (slv_mode == M_TX) begin
        if (slv_bits == 8) slv_mack = line;
        slv_bits++;
      end else if (slv_mode != M_IDLE) begin
        if (slv_bits < 8) slv_sh = {slv_sh[6:0], line};
        slv_bits++;
      end
    end else if (!scl && scl_prev) begin
      if (slv_mode == M_TX) begin
        if (slv_bits >= 1 && slv_bits <= 7) slv_pull = ~slv_tx[7 - slv_bits];
        else slv_pull = 1'b0;
      end else if (slv_mode != M_IDLE) begin
        if (slv_bits == 8) begin
          rx_log.push_back(slv_sh);
          slv_pull = 1'b0;
          slv_next = M_IDLE;
          if (slv_mode == M_DEV) begin
            if (slv_sh[7:1] == SLV_DEV) begin
              slv_pull = 1'b1;
              slv_next = slv_sh[0] ? M_TX : M_ADDR;
            end
          end else if (slv_mode == M_ADDR) begin
            slv_ptr  = slv_sh;
            slv_pull = 1'b1;
            slv_next = M_DATA;
          end else if (!slv_nack_data) begin
            slv_mem[slv_ptr] = slv_sh;
            slv_ptr  = slv_ptr + 8'd1;
            slv_pull = 1'b1;
            slv_next = M_DATA;
          end
        end else if (slv_bits == 9) begin
          slv_pull = 1'b0;
          slv_bits = 0;
          slv_mode = slv_next;
          if (slv_mode == M_TX) begin
            slv_tx   = slv_mem[slv_ptr];
            slv_pull = ~slv_tx[7];
          end
        end
      end
    end
    scl_prev = scl;
    sda_prev = ~(sda_oe | slv_pull);
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic       rw;
    logic [7:0] b0, b1, b2;
    int         nb;
    int         starts;
    logic       nack;
    logic [7:0] rdata;
    int         lat;
    int         acc;
  } exp_t;

  exp_t       exp_q [$];
  int         rd_idx = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] last_rdata = '0;
  int         rsp_times [$];
  int         b2b_viol = 0;

  task automatic push_exp(input logic rw, input logic [6:0] dev, input logic [7:0] addr,
                          input logic [7:0] wdata, input int acc);
    exp_t e;
    int   periods;
    e.rw = rw;
    e.acc = acc;
    e.b0 = {dev, 1'b0};
    e.b1 = addr;
    e.b2 = rw ? {dev, 1'b1} : wdata;
    if (dev != SLV_DEV) begin
      periods = 1 + 9 + 1;
      e.nb = 1; e.starts = 1; e.nack = 1'b1; e.rdata = '0;
    end else if (rw) begin
      periods = 39;
      e.nb = 3; e.starts = 2; e.nack = 1'b0; e.rdata = ref_mem[addr];
    end else if (slv_nack_data) begin
      periods = 29;
      e.nb = 3; e.starts = 1; e.nack = 1'b1; e.rdata = '0;
    end else begin
      periods = 29;
      e.nb = 3; e.starts = 1; e.nack = 1'b0; e.rdata = last_rdata;
      ref_mem[addr] = wdata;
    end
    e.lat = periods * BIT_CYC + 1;
    last_rdata = e.rdata;
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid) begin
        rsp_times.push_back(cyc);
        if (rd_idx >= exp_q.size()) begin
          check("unexpected_rsp", rsp_valid, 1'b0);
        end else begin
          exp_t e;
          logic [7:0] eb [3];
          e = exp_q[rd_idx];
          rd_idx++;
          eb = '{e.b0, e.b1, e.b2};
          check("rsp_nack", rsp_nack, e.nack);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("latency", cyc - e.acc + 1, e.lat);
          check("bus_byte_count", rx_log.size(), e.nb);
          for (int i = 0; i < e.nb; i++)
            check("bus_byte", (i < rx_log.size()) ? rx_log[i] : 8'hxx, eb[i]);
          check("start_count", slv_starts, e.starts);
          if (e.rw && !e.nack) check("master_nack_bit", slv_mack, 1'b1);
          check("scl_idle", scl, 1'b1);
          check("sda_idle", sda_oe, 1'b0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] addr,
                        input logic [7:0] wdata, input bit push, input bit keep);
    int n;
    @(negedge clk);
    cmd_rw = rw; cmd_dev = dev; cmd_addr = addr; cmd_wdata = wdata;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
      if (cmd_ready && busy) b2b_viol++;
    end
    if (!cmd_ready) check("accept_timeout", cmd_ready, 1'b1);
    else if (push) push_exp(rw, dev, addr, wdata, cyc + 1);
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && rd_idx < exp_q.size(); i++) @(negedge clk);
    check("rsp_timeout", rd_idx, exp_q.size());
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n0;
    logic rw;
    logic [6:0] dev;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

    repeat (3) @(negedge clk);
    check("reset_scl", scl, 1'b1);
    check("reset_sda_oe", sda_oe, 1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_rdata", rsp_rdata, 8'h00);
    check("reset_rsp_nack", rsp_nack, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_cmd_ready", cmd_ready, 1'b0);
    rst = 1'b0;

    do_cmd(1'b0, 7'h50, 8'h05, 8'hAB, 1'b1, 1'b0); wait_idle();
    do_cmd(1'b1, 7'h50, 8'h10, 8'h00, 1'b1, 1'b0); wait_idle();
    do_cmd(1'b0, 7'h23, 8'h07, 8'h11, 1'b1, 1'b0); wait_idle();
    do_cmd(1'b1, 7'h2C, 8'h01, 8'h00, 1'b1, 1'b0); wait_idle();
    slv_nack_data = 1'b1;
    do_cmd(1'b0, 7'h50, 8'h08, 8'h99, 1'b1, 1'b0); wait_idle();
    slv_nack_data = 1'b0;
    do_cmd(1'b1, 7'h50, 8'h05, 8'h00, 1'b1, 1'b0); wait_idle();

    // abort during the memory-address byte
    n0 = rsp_times.size();
    do_cmd(1'b0, 7'h50, 8'h33, 8'h77, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_scl", scl, 1'b1);
    check("abort_sda_oe", sda_oe, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_cmd_ready", cmd_ready, 1'b0);
    check("abort_rsp_rdata", rsp_rdata, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_rdata = '0;
    repeat (700) @(negedge clk);
    check("abort_no_rsp", rsp_times.size(), n0);
    do_cmd(1'b0, 7'h50, 8'h33, 8'h77, 1'b1, 1'b0); wait_idle();
    do_cmd(1'b1, 7'h50, 8'h33, 8'h00, 1'b1, 1'b0); wait_idle();

    // cmd_valid held across two writes
    n0 = rsp_times.size();
    b2b_viol = 0;
    do_cmd(1'b0, 7'h50, 8'h02, 8'hC3, 1'b1, 1'b1);
    do_cmd(1'b0, 7'h50, 8'h03, 8'h3C, 1'b1, 1'b0);
    wait_idle();
    check("b2b_ready_while_busy", b2b_viol, 0);
    check("b2b_rsp_count", rsp_times.size() - n0, 2);
    if (rsp_times.size() >= n0 + 2)
      check("b2b_spacing", rsp_times[n0 + 1] - rsp_times[n0], 29 * BIT_CYC + 2);

    for (int k = 0; k < 20; k++) begin
      rw  = 1'($urandom_range(0, 1));
      dev = ($urandom_range(0, 5) == 0) ? 7'(8'h10 + $urandom_range(0, 15)) : SLV_DEV;
      slv_nack_data = !rw && ($urandom_range(0, 7) == 0);
      do_cmd(rw, dev, 8'($urandom_range(0, 15)), 8'($urandom), 1'b1, 1'b0);
      wait_idle();
    end
    slv_nack_data = 1'b0;

    check("all_rsp_seen", rd_idx, exp_q.size());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
